// File: rtl/dsp_carry_normalizer.sv
// dsp_carry_normalizer
//
// Normalizes the stream of double-width DSP58 multiply-accumulate results in
// the FIOS Montgomery datapath. Each accepted result is added to the running
// carry. The low WORD_WIDTH bits go out as a result word, and the high part
// becomes the next carry. After WORD_COUNT results, one final carry word is
// emitted. It is tagged with last_o, and overflow_o shows whether the carry
// needed its extra bit.
//
// Ports:
//   clock_i       rising-edge clock
//   reset_i       asynchronous, active-high reset
//   start_i       begins an operand (honoured only while idle)
//   P_i           DSP result, 2*WORD_WIDTH bits
//   P_valid_i     P_i is valid this cycle
//   word_o        normalized result word (holds between valid pulses)
//   word_valid_o  word_o is valid (single-cycle pulse)
//   last_o        final carry word marker
//   overflow_o    final carry did not fit in WORD_WIDTH bits
//   busy_o        an operand is in progress
//
// Build option: define CARRY_NORM_OUT_REG_EN to add a second output register
// stage. This raises the latency from 1 to 2 cycles. With the extra stage,
// busy_o stays high until the delayed last_o is presented.

module dsp_carry_normalizer #(
    parameter int WORD_WIDTH = 23,
    parameter int WORD_COUNT = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [2*WORD_WIDTH-1:0] P_i,
    input  logic                    P_valid_i,
    output logic [WORD_WIDTH-1:0]   word_o,
    output logic                    word_valid_o,
    output logic                    last_o,
    output logic                    overflow_o,
    output logic                    busy_o
);

    localparam int CNT_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH:0]     carry_q, carry_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*WORD_WIDTH:0]   sum;

    // First output register stage.
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    ovf_q, ovf_d;
    logic                    busy_q, busy_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        word_d  = word_q;     // word_o holds its value between valid pulses
        valid_d = 1'b0;
        last_d  = 1'b0;
        ovf_d   = 1'b0;

        // Zero-extend both operands to 2*WORD_WIDTH+1 bits so the carry-out
        // of the top bit is kept.
        sum = {1'b0, P_i} + {{WORD_WIDTH{1'b0}}, carry_q};

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (P_valid_i) begin
                    word_d  = sum[WORD_WIDTH-1:0];
                    valid_d = 1'b1;
                    // The upper part is exactly WORD_WIDTH+1 bits wide.
                    // Well-formed operands never need more than that.
                    carry_d = sum[2*WORD_WIDTH:WORD_WIDTH];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                word_d  = carry_q[WORD_WIDTH-1:0];
                valid_d = 1'b1;
                last_d  = 1'b1;
                ovf_d   = carry_q[WORD_WIDTH];
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef CARRY_NORM_OUT_REG_EN
        // Stay busy for one more cycle while the delayed last word drains.
        busy_d = (state_d != IDLE) || (state_q == FLUSH);
`else
        busy_d = (state_d != IDLE);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            carry_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

`ifdef CARRY_NORM_OUT_REG_EN
    // Second output register stage.
    logic [WORD_WIDTH-1:0] word_r2;
    logic                  valid_r2;
    logic                  last_r2;
    logic                  ovf_r2;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            word_r2  <= '0;
            valid_r2 <= 1'b0;
            last_r2  <= 1'b0;
            ovf_r2   <= 1'b0;
        end else begin
            word_r2  <= word_q;
            valid_r2 <= valid_q;
            last_r2  <= last_q;
            ovf_r2   <= ovf_q;
        end
    end

    assign word_o       = word_r2;
    assign word_valid_o = valid_r2;
    assign last_o       = last_r2;
    assign overflow_o   = ovf_r2;
`else
    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign last_o       = last_q;
    assign overflow_o   = ovf_q;
`endif

    assign busy_o = busy_q;

endmodule
